// File: rtl/bm_pkg.sv
// Shared gamepad/bomberman constants: direction codes, button bit positions,
// default NES pad timing, and the facing-direction priority helpers.
package bm_pkg;

  localparam logic [1:0] CD_U = 2'b00;
  localparam logic [1:0] CD_R = 2'b01;
  localparam logic [1:0] CD_D = 2'b10;
  localparam logic [1:0] CD_L = 2'b11;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_U     = 4;
  localparam int BTN_D     = 5;
  localparam int BTN_L     = 6;
  localparam int BTN_R     = 7;

  localparam int POLL_DIV_DEF  = 1666667;
  localparam int LATCH_CYC_DEF = 1200;
  localparam int HALF_BIT_DEF  = 600;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_SAMPLE, ST_CLK_HI, ST_CLK_LO, ST_UPDATE
  } nes_st_e;

  // Direction vectors are indexed by CD code: [0]=U [1]=R [2]=D [3]=L,
  // so scanning upward gives the U,R,D,L priority.
  function automatic logic [1:0] first_dir(input logic [3:0] v);
    logic [1:0] r;
    r = CD_U;
    for (int i = 3; i >= 0; i--)
      if (v[i]) r = i[1:0];
    return r;
  endfunction

  function automatic logic [1:0] cd_sel(input logic [3:0] cur, input logic [3:0] prev,
                                        input logic [1:0] cd);
    logic [3:0] newp;
    newp = cur & ~prev;
    if (|newp)        return first_dir(newp);
    else if (cur[cd]) return cd;
    else if (|cur)    return first_dir(cur);
    else              return cd;
  endfunction

endpackage

// File: rtl/bm_nes_shifter.sv
// NES pad serial engine: free-running poll counter, latch strobe, 8 clocked
// samples into raw[7:0]; frame_done is high for the single UPDATE cycle.
module bm_nes_shifter
  import bm_pkg::*;
#(
  parameter int POLL_DIV  = POLL_DIV_DEF,
  parameter int LATCH_CYC = LATCH_CYC_DEF,
  parameter int HALF_BIT  = HALF_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] raw,
  output logic       frame_done
);

  localparam int CNT_W  = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int TMAX   = (LATCH_CYC > HALF_BIT) ? LATCH_CYC : HALF_BIT;
  localparam int TMR_W  = (TMAX > 2) ? $clog2(TMAX) : 1;

  nes_st_e          st, st_nxt;
  logic [CNT_W-1:0] poll_cnt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       sh, sh_nxt;
  logic             poll_tick;

  assign poll_tick = (poll_cnt == CNT_W'(POLL_DIV - 1));
  assign raw       = sh;

  always_comb begin
    st_nxt  = st;
    tmr_nxt = tmr;
    idx_nxt = idx;
    sh_nxt  = sh;
    case (st)
      ST_IDLE: begin
        // A tick seen outside IDLE is simply lost; polls never queue.
        if (poll_tick) begin
          st_nxt  = ST_LATCH;
          tmr_nxt = '0;
        end
      end
      ST_LATCH: begin
        if (tmr == TMR_W'(LATCH_CYC - 1)) begin
          st_nxt  = ST_SAMPLE;
          tmr_nxt = '0;
        end else tmr_nxt = tmr + TMR_W'(1);
      end
      ST_SAMPLE: begin
        sh_nxt[idx] = ~nes_data;
        tmr_nxt     = '0;
        st_nxt      = (idx == 3'd7) ? ST_UPDATE : ST_CLK_HI;
      end
      ST_CLK_HI: begin
        if (tmr == TMR_W'(HALF_BIT - 1)) begin
          st_nxt  = ST_CLK_LO;
          tmr_nxt = '0;
          idx_nxt = idx + 3'd1;
        end else tmr_nxt = tmr + TMR_W'(1);
      end
      ST_CLK_LO: begin
        if (tmr == TMR_W'(HALF_BIT - 1)) begin
          st_nxt  = ST_SAMPLE;
          tmr_nxt = '0;
        end else tmr_nxt = tmr + TMR_W'(1);
      end
      ST_UPDATE: begin
        idx_nxt = '0;
        st_nxt  = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Pad-facing strobes are flops decoded from the next state, so they never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      poll_cnt   <= '0;
      tmr        <= '0;
      idx        <= '0;
      sh         <= '0;
      nes_latch  <= 1'b0;
      nes_clk    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st         <= st_nxt;
      poll_cnt   <= poll_tick ? '0 : poll_cnt + CNT_W'(1);
      tmr        <= tmr_nxt;
      idx        <= idx_nxt;
      sh         <= sh_nxt;
      nes_latch  <= (st_nxt == ST_LATCH);
      nes_clk    <= (st_nxt == ST_CLK_HI);
      frame_done <= (st_nxt == ST_UPDATE);
    end
  end

endmodule

// File: rtl/bm_controller_in.sv
// Bomberman gamepad front end: opposite-pair masking, facing-direction (cd)
// tracking and registered button levels. Optional macro BM_CTRL_FILTER_EN.
module bm_controller_in
  import bm_pkg::*;
#(
  parameter int POLL_DIV  = POLL_DIV_DEF,
  parameter int LATCH_CYC = LATCH_CYC_DEF,
  parameter int HALF_BIT  = HALF_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic       L,
  output logic       R,
  output logic       U,
  output logic       D,
  output logic       A,
  output logic       B,
  output logic       start,
  output logic       sel,
  output logic [1:0] cd,
  output logic       btn_valid
);

  logic [7:0] raw, src;
  logic       frame_done;
  logic       u_m, d_m, l_m, r_m;
  logic [3:0] dirs_now, dirs_prev;
  logic [1:0] cd_nxt;

  bm_nes_shifter #(
    .POLL_DIV (POLL_DIV),
    .LATCH_CYC(LATCH_CYC),
    .HALF_BIT (HALF_BIT)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .raw       (raw),
    .frame_done(frame_done)
  );

`ifdef BM_CTRL_FILTER_EN
  // A bit moves only when this frame's raw sample matches the previous raw sample.
  logic [7:0] prev_raw, filt, agree;
  assign agree = ~(raw ^ prev_raw);
  assign src   = (raw & agree) | (filt & ~agree);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_raw <= '0;
      filt     <= '0;
    end else if (frame_done) begin
      prev_raw <= raw;
      filt     <= src;
    end
  end
`else
  assign src = raw;
`endif

  assign u_m = src[BTN_U] & ~src[BTN_D];
  assign d_m = src[BTN_D] & ~src[BTN_U];
  assign l_m = src[BTN_L] & ~src[BTN_R];
  assign r_m = src[BTN_R] & ~src[BTN_L];

  assign dirs_now  = {l_m, d_m, r_m, u_m};
  assign dirs_prev = {L, D, R, U};
  assign cd_nxt    = cd_sel(dirs_now, dirs_prev, cd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {L, R, U, D}       <= '0;
      {A, B, start, sel} <= '0;
      cd                 <= CD_D;
      btn_valid          <= 1'b0;
    end else begin
      btn_valid <= frame_done;
      if (frame_done) begin
        U     <= u_m;
        D     <= d_m;
        L     <= l_m;
        R     <= r_m;
        A     <= src[BTN_A];
        B     <= src[BTN_B];
        sel   <= src[BTN_SEL];
        start <= src[BTN_START];
        cd    <= cd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bm_controller_in.sv
// Bench for bm_controller_in: NES pad model, reference decoder feeding a
// scoreboard queue, compared on each btn_valid pulse.
module tb_bm_controller_in;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk;
  logic       L, R, U, D, A, B, start, sel, btn_valid;
  logic [1:0] cd;

  bm_controller_in #(.POLL_DIV(200), .LATCH_CYC(4), .HALF_BIT(3)) dut (
    .clk(clk), .reset(reset), .nes_data(nes_data), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .L(L), .R(R), .U(U), .D(D), .A(A), .B(B),
    .start(start), .sel(sel), .cd(cd), .btn_valid(btn_valid)
  );

  always #5 clk = ~clk;

  // Pad: loads buttons while latched, presents bit 0, advances on nes_clk rise.
  logic [7:0] pad_btn = 8'h00;
  logic [7:0] pad_sh  = 8'h00;
  logic [3:0] pad_pos = 4'd0;
  logic       pad_clk_d = 1'b0;
  always @(posedge clk) begin
    if (nes_latch) begin
      pad_pos <= 4'd0;
      pad_sh  <= pad_btn;
    end else if (nes_clk && !pad_clk_d) pad_pos <= pad_pos + 4'd1;
    pad_clk_d <= nes_clk;
  end
  assign nes_data = (pad_pos < 4'd8) ? ~pad_sh[pad_pos[2:0]] : 1'b0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected outputs, packed as {R,L,D,U,start,sel,B,A}.
  typedef struct packed { logic [7:0] outs; logic [1:0] cd; } exp_t;
  exp_t sb[$];

  logic [3:0] m_prev = 4'd0;   // previous masked dirs, [0]U [1]R [2]D [3]L
  logic [1:0] m_cd   = 2'b10;
  logic [7:0] m_praw = 8'd0, m_filt = 8'd0;

  task automatic model_reset();
    m_prev = 4'd0; m_cd = 2'b10; m_praw = 8'd0; m_filt = 8'd0;
  endtask

  task automatic model_push(input logic [7:0] b);
    logic [7:0] s;
    logic       u, d, l, r;
    logic [3:0] cur, np;
    logic       found;
    exp_t       e;
`ifdef BM_CTRL_FILTER_EN
    for (int i = 0; i < 8; i++) s[i] = (b[i] == m_praw[i]) ? b[i] : m_filt[i];
    m_praw = b;
    m_filt = s;
`else
    s = b;
`endif
    u = s[4] && !s[5]; d = s[5] && !s[4];
    l = s[6] && !s[7]; r = s[7] && !s[6];
    cur = {l, d, r, u};
    np  = cur & ~m_prev;
    found = 1'b0;
    if (np != 4'd0) begin
      for (int i = 0; i < 4; i++) if (np[i] && !found) begin m_cd = 2'(i); found = 1'b1; end
    end else if (!cur[m_cd]) begin
      for (int i = 0; i < 4; i++) if (cur[i] && !found) begin m_cd = 2'(i); found = 1'b1; end
    end
    m_prev = cur;
    e.outs = {r, l, d, u, s[3], s[2], s[1], s[0]};
    e.cd   = m_cd;
    sb.push_back(e);
  endtask

  int lat_n, hi_n, rise_n;

  task automatic wait_frame();
    logic prev_clk;
    bit   seen;
    exp_t e;
    lat_n = 0; hi_n = 0; rise_n = 0; prev_clk = nes_clk; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      lat_n += int'(nes_latch);
      hi_n  += int'(nes_clk);
      if (nes_clk && !prev_clk) rise_n++;
      prev_clk = nes_clk;
      seen = btn_valid;
    end
    chk("btn_valid_seen", 32'(seen), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk("buttons", 32'({R, L, D, U, start, sel, B, A}), 32'(e.outs));
      chk("cd", 32'(cd), 32'(e.cd));
    end else if (seen) chk("sb_nonempty", 32'(sb.size()), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] b);
    pad_btn = b;
    model_push(b);
    wait_frame();
  endtask

  initial begin
    logic prev_clk;
    int   rises;
    bit   hit;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(nes_latch), 32'd0);
    chk("rst_clk", 32'(nes_clk), 32'd0);
    chk("rst_btns", 32'({R, L, D, U, start, sel, B, A}), 32'd0);
    chk("rst_cd", 32'(cd), 32'd2);
    chk("rst_valid", 32'(btn_valid), 32'd0);
    reset = 1'b1;

    // 1: first poll lands exactly POLL_DIV cycles after release
    repeat (199) @(posedge clk);
    #1 chk("latch_pre", 32'(nes_latch), 32'd0);
    @(posedge clk);
    #1 chk("latch_rise", 32'(nes_latch), 32'd1);
    model_push(8'h00);
    wait_frame();
    chk("latch_cycles", 32'(lat_n), 32'd4);
    chk("clk_rises", 32'(rise_n), 32'd7);
    chk("clk_hi_cycles", 32'(hi_n), 32'd21);
    @(negedge clk);
    chk("valid_one_cycle", 32'(btn_valid), 32'd0);

    // 2-4: directions, masking, cd priority, release
    run_frame(8'h10);   // U
    run_frame(8'h90);   // U+R, R new
    run_frame(8'h30);   // U+D masked
    run_frame(8'hC1);   // L+R masked, A
    run_frame(8'h80);   // R
    run_frame(8'h80);   // hold R
    run_frame(8'h00);   // release, cd kept
    run_frame(8'h90);   // U,R both new -> U wins
    run_frame(8'h80);   // U gone, R held
    run_frame(8'h40);   // L
    run_frame(8'h0E);   // B, select, start

    // 5: reset during CLK_HI of bit 3
    run_frame(8'h10);
    pad_btn = 8'h80;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin @(negedge clk); hit = nes_latch; end
    chk("latch_seen", 32'(hit), 32'd1);
    rises = 0; prev_clk = nes_clk; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (nes_clk && !prev_clk) rises++;
      prev_clk = nes_clk;
      hit = (rises == 4);
    end
    chk("bit3_clk_hi", 32'(nes_clk), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_clk", 32'(nes_clk), 32'd0);
    chk("abort_btns", 32'({R, L, D, U, start, sel, B, A}), 32'd0);
    chk("abort_cd", 32'(cd), 32'd2);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    model_push(8'h80);
    wait_frame();

    // 6: A glitch vs held A
    run_frame(8'h01);
    run_frame(8'h00);
    run_frame(8'h01);
    run_frame(8'h01);
    run_frame(8'h00);
    run_frame(8'h00);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
